// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder
// Takes one zigzag-ordered block of 64 signed coefficients and emits JPEG
// entropy symbols one per handshake: a DC difference, then AC (run,size,amp)
// symbols, ZRL for zero runs of 16 or more, and EOB when the block tail is zero.
// Symbol fields depend only on registered state, so they hold steady under
// downstream backpressure.
module zigzag_rle_encoder #(
   parameter int COEF_WIDTH = 8,
   parameter int RUN_WIDTH  = 6
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       blk_valid,
   output logic                       blk_ready,
   input  logic [64*COEF_WIDTH-1:0]   blk_data,
   input  logic                       dc_clear,
   output logic                       sym_valid,
   input  logic                       sym_ready,
   output logic                       sym_is_dc,
   output logic [3:0]                 sym_run,
   output logic [3:0]                 sym_size,
   output logic [COEF_WIDTH:0]        sym_amp,
   output logic                       sym_last,
   output logic                       busy
);

   localparam int DIFF_W = COEF_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DC,
      S_AC,
      S_EOB
   } state_t;

   typedef struct packed {
      logic [3:0]        size;
      logic [DIFF_W-1:0] amp;
   } enc_t;

   // Magnitude category and JPEG amplitude bits (ones' complement for negatives).
   function automatic enc_t encode(input logic signed [DIFF_W-1:0] v);
      enc_t              e;
      logic [DIFF_W-1:0] mag;
      logic [DIFF_W-1:0] vm1;
      logic [DIFF_W:0]   one_sh;
      logic [DIFF_W-1:0] mask;
      mag    = v[DIFF_W-1] ? -v : v;
      e.size = '0;
      for (int i = 0; i < DIFF_W; i++) begin
         if (mag[i]) e.size = 4'(i + 1);
      end
      one_sh = (DIFF_W+1)'(1) << e.size;
      mask   = DIFF_W'(one_sh - (DIFF_W+1)'(1));
      vm1    = v - DIFF_W'(1);
      e.amp  = (v[DIFF_W-1] ? vm1 : v) & mask;
      return e;
   endfunction

   state_t                      state;
   state_t                      state_next;
   // Packed [0:63] puts element 0 (DC) in the most significant byte, matching blk_data.
   logic [0:63][COEF_WIDTH-1:0] blk_q;
   logic [COEF_WIDTH-1:0]       pred_q;
   logic [RUN_WIDTH-1:0]        run_q;
   logic [5:0]                  idx_q;

   logic [COEF_WIDTH-1:0]       coef_cur;
   logic                        coef_zero;
   logic                        idx_last;
   logic                        zrl_due;
   logic signed [DIFF_W-1:0]    dc_diff;
   logic signed [DIFF_W-1:0]    ac_val;
   enc_t                        dc_enc;
   enc_t                        ac_enc;

   assign coef_cur  = blk_q[idx_q];
   assign coef_zero = (coef_cur == '0);
   assign idx_last  = (idx_q == 6'd63);
   assign zrl_due   = (run_q >= RUN_WIDTH'(16));
   assign dc_diff   = $signed({blk_q[0][COEF_WIDTH-1], blk_q[0]})
                    - $signed({pred_q[COEF_WIDTH-1], pred_q});
   assign ac_val    = $signed({coef_cur[COEF_WIDTH-1], coef_cur});
   assign dc_enc    = encode(dc_diff);
   assign ac_enc    = encode(ac_val);

   assign blk_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create ordering-dependent races.
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // Next-state decode and symbol field presentation.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
      state_next = state;
      sym_valid  = 1'b0;
      sym_is_dc  = 1'b0;
      sym_run    = '0;
      sym_size   = '0;
      sym_amp    = '0;
      sym_last   = 1'b0;
      case (state)
         S_IDLE: begin
            if (blk_valid) state_next = S_DC;
         end
         S_DC: begin
            sym_valid = 1'b1;
            sym_is_dc = 1'b1;
            sym_size  = dc_enc.size;
            sym_amp   = dc_enc.amp;
            if (sym_ready) state_next = S_AC;
         end
         S_AC: begin
            if (coef_zero) begin
               if (idx_last) state_next = S_EOB;
            end else if (zrl_due) begin
               sym_valid = 1'b1;
               sym_run   = 4'd15;
            end else begin
               sym_valid = 1'b1;
               sym_run   = run_q[3:0];
               sym_size  = ac_enc.size;
               sym_amp   = ac_enc.amp;
               sym_last  = idx_last;
               if (sym_ready && idx_last) state_next = S_IDLE;
            end
         end
         S_EOB: begin
            sym_valid = 1'b1;
            sym_last  = 1'b1;
            if (sym_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Block capture on acceptance.
   always_ff @(posedge clock) begin
      // NOTE: the block copy is deliberately not reset; it is only read after a fresh block has been loaded into it.
      if (state == S_IDLE && blk_valid) blk_q <= blk_data;
   end

   // DC predictor, zero-run counter and coefficient index.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pred_q <= '0;
         run_q  <= '0;
         idx_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dc_clear) pred_q <= '0;
            end
            S_DC: begin
               if (sym_ready) begin
                  pred_q <= blk_q[0];
                  idx_q  <= 6'd1;
                  run_q  <= '0;
               end
            end
            S_AC: begin
               if (coef_zero) begin
                  run_q <= run_q + RUN_WIDTH'(1);
                  if (!idx_last) idx_q <= idx_q + 6'd1;
               end else if (sym_ready) begin
                  if (zrl_due) begin
                     run_q <= run_q - RUN_WIDTH'(16);
                  end else begin
                     run_q <= '0;
                     if (!idx_last) idx_q <= idx_q + 6'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// tb_zigzag_rle_encoder
// Directed blocks checked against a symbol-list model of JPEG run-length coding.
module tb_zigzag_rle_encoder;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         dc_clear;
   logic         sym_valid;
   logic         sym_ready;
   logic         sym_is_dc;
   logic [3:0]   sym_run;
   logic [3:0]   sym_size;
   logic [8:0]   sym_amp;
   logic         sym_last;
   logic         busy;

   zigzag_rle_encoder dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .dc_clear  (dc_clear),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_is_dc (sym_is_dc),
      .sym_run   (sym_run),
      .sym_size  (sym_size),
      .sym_amp   (sym_amp),
      .sym_last  (sym_last),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       dc;
      logic [3:0] run;
      logic [3:0] size;
      logic [8:0] amp;
      logic       last;
   } sym_t;

   sym_t exp_q[$];
   int   coef[64];
   int   model_pred = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   bit   stall_dc_en = 1'b0;
   bit   stall_zrl_en = 1'b0;
   int   stall_cycles = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int size_of(input int v);
      int m = (v < 0) ? -v : v;
      int s = 0;
      while ((1 << s) <= m) s++;
      return s;
   endfunction

   function automatic int amp_of(input int v);
      int s = size_of(v);
      return (v >= 0) ? v : v + (1 << s) - 1;
   endfunction

   function automatic sym_t mk(input bit dc, input int run, input int v, input bit last);
      sym_t s;
      s.dc   = dc;
      s.run  = 4'(run);
      s.size = 4'(size_of(v));
      s.amp  = 9'(amp_of(v));
      s.last = last;
      return s;
   endfunction

   function automatic sym_t lit(input bit dc, input int run, input int size, input int amp, input bit last);
      sym_t s;
      s.dc   = dc;
      s.run  = 4'(run);
      s.size = 4'(size);
      s.amp  = 9'(amp);
      s.last = last;
      return s;
   endfunction

   // Expected symbol list for the block in coef[], straight from the coding rules.
   task automatic build_expected(input bit clr);
      int run = 0;
      if (clr) model_pred = 0;
      exp_q.push_back(mk(1'b1, 0, coef[0] - model_pred, 1'b0));
      model_pred = coef[0];
      for (int k = 1; k < 64; k++) begin
         if (coef[k] == 0) begin
            run++;
         end else begin
            while (run >= 16) begin
               exp_q.push_back(mk(1'b0, 15, 0, 1'b0));
               run -= 16;
            end
            exp_q.push_back(mk(1'b0, run, coef[k], k == 63));
            run = 0;
         end
      end
      if (coef[63] == 0) exp_q.push_back(mk(1'b0, 0, 0, 1'b1));
   endtask

   function automatic logic [511:0] pack_block();
      logic [511:0] d = '0;
      for (int k = 0; k < 64; k++) d[511-8*k -: 8] = 8'(coef[k]);
      return d;
   endfunction

   task automatic clear_block();
      for (int k = 0; k < 64; k++) coef[k] = 0;
   endtask

   // Offers the block, then waits (bounded) for the encoder to return to idle.
   task automatic send_block(input bit clr, input bit busy_clr, output int cyc);
      check("blk_ready_before_accept", 32'(blk_ready), 32'd1);
      blk_data  = pack_block();
      blk_valid = 1'b1;
      dc_clear  = clr;
      @(posedge clock); #1;
      blk_valid = 1'b0;
      dc_clear  = 1'b0;
      cyc = 0;
      while (busy && cyc < 500) begin
         dc_clear = busy_clr && (cyc < 8);
         @(posedge clock); #1;
         cyc++;
      end
      dc_clear = 1'b0;
      check("block_done_busy", 32'(busy), 32'd0);
      check("block_all_syms_seen", 32'(exp_q.size()), 32'd0);
   endtask

   // Downstream ready: normally high, held low 5 cycles on the first DC and first ZRL when enabled.
   initial begin
      int  hold = 0;
      bit  dc_done = 1'b0;
      bit  zrl_done = 1'b0;
      sym_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         if (hold > 0) begin
            hold--;
            sym_ready = 1'b0;
         end else begin
            sym_ready = 1'b1;
            if (sym_valid && stall_dc_en && !dc_done && sym_is_dc) begin
               dc_done = 1'b1;
               hold = 4;
               sym_ready = 1'b0;
            end else if (sym_valid && stall_zrl_en && !zrl_done && !sym_is_dc
                         && sym_run == 4'd15 && sym_size == 4'd0) begin
               zrl_done = 1'b1;
               hold = 4;
               sym_ready = 1'b0;
            end
         end
         if (!sym_ready && sym_valid) stall_cycles++;
      end
   end

   // Compare process: every cycle, the presented symbol must equal the head of the expected list.
   always @(negedge clock) begin
      if (chk_en) begin
         if (sym_valid) begin
            check("sym_expected_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               check("sym_fields", 32'({sym_is_dc, sym_run, sym_size, sym_amp, sym_last}), 32'(exp_q[0]));
               if (sym_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("sym_fields_idle_zero", 32'({sym_is_dc, sym_run, sym_size, sym_amp, sym_last}), 32'd0);
         end
      end
   end

   initial begin
      int cyc;
      blk_valid = 1'b0;
      dc_clear  = 1'b0;
      blk_data  = '0;
      reset_n   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("in_reset_sym_valid", 32'(sym_valid), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // T1: reset state, first DC uses predictor 0
      check("reset_blk_ready", 32'(blk_ready), 32'd1);
      check("reset_sym_valid", 32'(sym_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      chk_en = 1'b1;
      clear_block();
      coef[0] = -7;
      build_expected(1'b0);
      check("t1_model_dc", 32'(exp_q[0]), 32'(lit(1, 0, 3, 0, 0)));
      send_block(1'b0, 1'b0, cyc);

      // T2: dc_clear at accept, DC 5, all-zero AC -> 63 scan cycles then EOB
      clear_block();
      coef[0] = 5;
      build_expected(1'b1);
      check("t2_model_count", 32'(exp_q.size()), 32'd2);
      check("t2_model_dc", 32'(exp_q[0]), 32'(lit(1, 0, 3, 5, 0)));
      check("t2_model_eob", 32'(exp_q[1]), 32'(lit(0, 0, 0, 0, 1)));
      send_block(1'b1, 1'b0, cyc);
      check("t2_busy_cycles", 32'(cyc), 32'd65);

      // T3: DC diff -2
      clear_block();
      coef[0] = 3;
      build_expected(1'b0);
      check("t3_model_dc", 32'(exp_q[0]), 32'(lit(1, 0, 2, 1, 0)));
      send_block(1'b0, 1'b0, cyc);

      // T4: AC -1, ZRL, AC 7; dc_clear pulsed while busy must be ignored
      clear_block();
      coef[0]  = 3;
      coef[1]  = -1;
      coef[20] = 7;
      build_expected(1'b0);
      check("t4_model_count", 32'(exp_q.size()), 32'd5);
      check("t4_model_ac1", 32'(exp_q[1]), 32'(lit(0, 0, 1, 0, 0)));
      check("t4_model_zrl", 32'(exp_q[2]), 32'(lit(0, 15, 0, 0, 0)));
      check("t4_model_ac20", 32'(exp_q[3]), 32'(lit(0, 2, 3, 7, 0)));
      send_block(1'b0, 1'b1, cyc);

      // T5: only coef63 = -128 -> three ZRL then final AC, no EOB
      clear_block();
      coef[63] = -128;
      build_expected(1'b0);
      check("t5_model_count", 32'(exp_q.size()), 32'd5);
      check("t5_model_dc", 32'(exp_q[0]), 32'(lit(1, 0, 2, 0, 0)));
      check("t5_model_last", 32'(exp_q[4]), 32'(lit(0, 14, 8, 127, 1)));
      send_block(1'b0, 1'b0, cyc);

      // T6a: backpressure on DC and on ZRL
      clear_block();
      coef[0]  = 100;
      coef[40] = -9;
      build_expected(1'b0);
      check("t6_model_ac40", 32'(exp_q[3]), 32'(lit(0, 7, 4, 6, 0)));
      stall_dc_en  = 1'b1;
      stall_zrl_en = 1'b1;
      send_block(1'b0, 1'b0, cyc);
      check("t6_stall_cycles", 32'(stall_cycles), 32'd10);

      // T6b: reset pulse mid-AC drops the block and clears the predictor
      clear_block();
      coef[0]  = 50;
      coef[63] = 1;
      build_expected(1'b0);
      blk_data  = pack_block();
      blk_valid = 1'b1;
      @(posedge clock); #1;
      blk_valid = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
      end
      check("t6_busy_mid_ac", 32'(busy), 32'd1);
      reset_n = 1'b0;
      exp_q.delete();
      model_pred = 0;
      #1;
      check("t6_reset_sym_valid", 32'(sym_valid), 32'd0);
      check("t6_reset_blk_ready", 32'(blk_ready), 32'd1);
      check("t6_reset_busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      clear_block();
      coef[0] = 20;
      coef[5] = -3;
      build_expected(1'b0);
      check("t6_model_dc_after_reset", 32'(exp_q[0]), 32'(lit(1, 0, 5, 20, 0)));
      send_block(1'b0, 1'b0, cyc);

      // T7: DC extremes and a dense AC block ending on a nonzero coef63
      clear_block();
      coef[0] = -128;
      build_expected(1'b0);
      check("t7_model_dc_neg", 32'(exp_q[0]), 32'(lit(1, 0, 8, 107, 0)));
      send_block(1'b0, 1'b0, cyc);
      clear_block();
      coef[0] = 127;
      for (int k = 3; k < 64; k += 3) coef[k] = ((k * 37) % 256) - 128;
      build_expected(1'b0);
      check("t7_model_dc_pos", 32'(exp_q[0]), 32'(lit(1, 0, 8, 255, 0)));
      send_block(1'b0, 1'b0, cyc);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
